// File: rtl/game_pkg.sv
// Shared definitions for the game controller and the scoring block:
// state encoding, preset tables and the word-index LFSR constants.
package game_pkg;

  typedef enum logic [1:0] {
    ST_SELECT    = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_INGAME    = 2'd2,
    ST_FINISH    = 2'd3
  } game_state_t;

  // Preset tables, element [0] is the rightmost entry.
  localparam logic [3:0][6:0] TIME_PRESETS = {7'd120, 7'd60, 7'd30, 7'd15};
  localparam logic [3:0][6:0] WORD_PRESETS = {7'd100, 7'd50, 7'd25, 7'd10};

  // Fibonacci LFSR x^10 + x^7 + 1: feedback from bits 9 and 6.
  localparam logic [9:0] LFSR_TAPS = 10'h240;
  localparam logic [9:0] LFSR_SEED = 10'h001;

  // Game ticks per countdown second.
  localparam int SUB_TICKS = 100;

  localparam logic [1:0] PRESET_IDX_RST = 2'd1;

  // Time limit (mode 0) or word target (mode 1) for a preset index.
  function automatic logic [6:0] preset_value(input logic m, input logic [1:0] idx);
    return m ? WORD_PRESETS[idx] : TIME_PRESETS[idx];
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Game tick strobe: one-cycle pulse every TICK_DIV clocks, restartable by clr.
// The strobe is registered one cycle early so that the consuming logic acts
// on the edge that completes each TICK_DIV-cycle period.
module tick_gen #(
  parameter int TICK_DIV = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  // Next divider value: restart on clr, wrap after the last count.
  always_comb begin
    cnt_nxt = cnt + CW'(1);
    if (clr || cnt == LAST) cnt_nxt = '0;
  end

  // Divider register and pre-announced strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      tick <= (cnt_nxt == LAST);
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Game flow controller: preset selection, countdown, in-game and finish
// phases, plus a free-running pseudo-random word index.
// Control inputs (start, abort, sel_up, sel_down) are single-cycle pulses
// with no handshake: each is acted on in the cycle it is high, and the
// effect is visible on the registered outputs one cycle later.
module game_ctrl
  import game_pkg::*;
#(
  parameter int TICK_DIV = 1000000,
  parameter int CD_SEC   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       sel_up,
  input  logic       sel_down,
  input  logic       mode_sw,
  input  logic       finish,
  output logic [1:0] state,
  output logic       mode,
  output logic [6:0] value,
  output logic [9:0] random_id,
  output logic [1:0] cd_digit,
  output logic       tick
);

  game_state_t st;
  logic [1:0]  preset_idx;
  logic [1:0]  idx_nxt;
  logic [6:0]  sub_cnt;

  logic go_countdown, go_abort, go_finish, go_menu, sec_done, go_ingame;
  logic state_chg;

  assign state = st;

  // Transition decode; abort outranks finish and tick.
  assign go_countdown = (st == ST_SELECT) && start;
  assign go_abort     = ((st == ST_COUNTDOWN) || (st == ST_INGAME)) && abort;
  assign go_finish    = (st == ST_INGAME) && finish && !abort;
  assign go_menu      = (st == ST_FINISH) && start;
  assign sec_done     = (st == ST_COUNTDOWN) && tick && (sub_cnt == 7'(SUB_TICKS - 1));
  assign go_ingame    = sec_done && (cd_digit == 2'd1) && !abort;
  assign state_chg    = go_countdown | go_abort | go_finish | go_menu | go_ingame;

  // Saturating preset index; simultaneous up/down cancels.
  always_comb begin
    idx_nxt = preset_idx;
    if (sel_up && !sel_down && preset_idx != 2'd3) idx_nxt = preset_idx + 2'd1;
    else if (sel_down && !sel_up && preset_idx != 2'd0) idx_nxt = preset_idx - 2'd1;
  end

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_chg),
    .tick (tick)
  );

  // Game FSM with registered mode, value, countdown digit and sub-counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= ST_SELECT;
      mode       <= 1'b0;
      preset_idx <= PRESET_IDX_RST;
      value      <= preset_value(1'b0, PRESET_IDX_RST);
      cd_digit   <= 2'd0;
      sub_cnt    <= 7'd0;
    end else begin
      case (st)
        ST_SELECT: begin
          mode       <= mode_sw;
          preset_idx <= idx_nxt;
          value      <= preset_value(mode_sw, idx_nxt);
          if (go_countdown) begin
            st       <= ST_COUNTDOWN;
            cd_digit <= 2'(CD_SEC);
            sub_cnt  <= 7'd0;
          end
        end
        ST_COUNTDOWN: begin
          if (go_abort) begin
            st <= ST_SELECT;
          end else if (sec_done) begin
            sub_cnt  <= 7'd0;
            cd_digit <= cd_digit - 2'd1;
            if (go_ingame) st <= ST_INGAME;
          end else if (tick) begin
            sub_cnt <= sub_cnt + 7'd1;
          end
        end
        ST_INGAME: begin
          if (go_abort)       st <= ST_SELECT;
          else if (go_finish) st <= ST_FINISH;
        end
        ST_FINISH: begin
          if (go_menu) st <= ST_SELECT;
        end
        default: st <= ST_SELECT;
      endcase
    end
  end

  // Word-index LFSR, advances every cycle in every state.
  always_ff @(posedge clk) begin
    if (rst) random_id <= LFSR_SEED;
    else     random_id <= {random_id[8:0], ^(random_id & LFSR_TAPS)};
  end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 1000000, clk cycles per 10 ms game tick (100 Hz at 100 MHz).
REQ-002 Parameter CD_SEC, default 3, countdown length in seconds.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle pulse, debounced start/confirm button.
REQ-006 abort  input  1  one-cycle pulse, return to menu.
REQ-007 sel_up  input  1  one-cycle pulse, next preset.
REQ-008 sel_down  input  1  one-cycle pulse, previous preset.
REQ-009 mode_sw  input  1  0 = timed game, 1 = word-count game.
REQ-010 finish  input  1  level from the scoring block; game-over condition.
REQ-011 state  output  2  0 SELECT, 1 COUNTDOWN, 2 INGAME, 3 FINISH.
REQ-012 mode  output  1  game mode latched at start.
REQ-013 value  output  7  time limit in seconds (mode 0) or word target (mode 1).
REQ-014 random_id  output  10  free-running pseudo-random word index.
REQ-015 cd_digit  output  2  countdown seconds remaining, for display.
REQ-016 tick  output  1  one-cycle 100 Hz strobe.

Function
REQ-017 tick SHALL pulse for one cycle every TICK_DIV cycles; the divider SHALL be cleared on every state change.
REQ-018 SELECT: mode SHALL follow mode_sw every cycle; preset index SHALL saturate at 0 and 3 (sel_up at 3 and sel_down at 0 are ignored).
REQ-019 value SHALL be presets {15,30,60,120} for mode 0 and {10,25,50,100} for mode 1, indexed by preset index.
REQ-020 sel_up and sel_down asserted in the same cycle SHALL leave the index unchanged.
REQ-021 In SELECT, start SHALL move to COUNTDOWN on the next cycle, with cd_digit = CD_SEC and a 100-tick sub-counter = 0.
REQ-022 mode, value and the preset index SHALL be frozen outside SELECT.
REQ-023 COUNTDOWN: each tick SHALL increment the sub-counter; at 100 it SHALL clear and cd_digit SHALL decrement.
REQ-024 When cd_digit is 1 and the sub-counter reaches 100, state SHALL move to INGAME and cd_digit SHALL become 0.
REQ-025 COUNTDOWN SHALL last exactly CD_SEC*100*TICK_DIV cycles.
REQ-026 INGAME: finish = 1 SHALL move to FINISH on the next cycle.
REQ-027 FINISH: start SHALL move to SELECT; finish is ignored.
REQ-028 abort in COUNTDOWN or INGAME SHALL move to SELECT, with priority over finish and tick in the same cycle; abort in SELECT or FINISH SHALL be ignored.
REQ-029 start SHALL be ignored in COUNTDOWN and INGAME.
REQ-030 random_id SHALL be a 10-bit Fibonacci LFSR (x^10 + x^7 + 1) advancing every cycle in all states; it SHALL never be 0.
REQ-031 All outputs SHALL be registered; a state change SHALL be visible on state one cycle after the causing input.

Reset
REQ-032 rst SHALL force state = SELECT, mode = 0, preset index = 1 (value = 30), cd_digit = 0, tick = 0, dividers = 0, random_id = 10'h001, on the next edge.
REQ-033 rst mid-game SHALL abandon the countdown or game with no residual tick or state pulse.
REQ-034 rst SHALL have priority over all other inputs.

Structure
REQ-035 Shared package game_pkg SHALL hold the state encoding, both preset tables, and the LFSR tap constant; the scoring block SHALL import the same encoding.
REQ-036 The 100 Hz strobe SHALL be a sub-module tick_gen (clk, rst, clr, tick) parameterised by TICK_DIV.

Verification (TICK_DIV=4, CD_SEC=3)
REQ-037 rst, then start -> state 1 next cycle, cd_digit 3; cd_digit goes 2 after 400 cycles; state 2 at cycle 1200, cd_digit 0.
REQ-038 In SELECT, mode_sw=1, sel_up x5 -> value 100 (saturated); sel_down x4 -> value 10; sel_up and sel_down together -> value unchanged.
REQ-039 INGAME, finish=1 -> state 3 next cycle; start -> state 0; changing mode_sw while in INGAME leaves mode unchanged.
REQ-040 COUNTDOWN at cycle 600, abort -> state 0, cd_digit held; abort and finish in the same INGAME cycle -> state 0, not 3.
REQ-041 Run 1023 cycles from reset -> random_id returns to 10'h001 with no zero value seen; rst asserted in INGAME -> state 0 and random_id 10'h001 next cycle.
